// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU.
// Operands are registered on accept, and the result is returned on the owner's response channel.
//
//  state | meaning
//  IDLE  | no operation in flight; the granted requester sees req*_ready
//  EXEC  | alu_* driven from registers; result captured at the end of this cycle
//  RESP  | owner's rsp_valid high, result held until rsp_ready
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
    logic              rsp0_zero_q, rsp0_zero_d;
    logic              rsp1_zero_q, rsp1_zero_d;

    logic idle;
    logic any_req;
    logic grant_port;
    logic owner_rsp_ready;

    assign idle            = (state_q == ST_IDLE);
    assign any_req         = req0_valid | req1_valid;
    // Under contention the port that did not win last time goes next.
    assign grant_port      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // rst_n gates ready so it stays low while reset is held, even with valid high.
    assign req0_ready  = rst_n && idle && req0_valid && !grant_port;
    assign req1_ready  = rst_n && idle && req1_valid && grant_port;
    assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ST_RESP) && owner_q;
    assign busy        = !idle;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_EXEC;
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    alu_op_d     = grant_port ? req1_op : req0_op;
                    alu_a_d      = grant_port ? req1_a  : req0_a;
                    alu_b_d      = grant_port ? req1_b  : req0_b;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    rsp1_result_d = alu_result;
                    rsp1_zero_d   = alu_zero;
                end else begin
                    rsp0_result_d = alu_result;
                    rsp0_zero_d   = alu_zero;
                end
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0, the main execute stage, and port 1, the address/branch helper.
- Each requester presents an opcode and operands with a valid/ready handshake. The block arbitrates round-robin, drives the shared ALU from registered operands, captures the result, and returns it on the owning requester's response channel with backpressure.
- Sits between the ALU operation decoder and the ALU instance.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, ALU operation select width (matches the ALU Operation encoding)

Ports:
- clk input 1 rising-edge clock
- rst_n input 1 asynchronous active-low reset
- req0_valid input 1 port-0 request valid
- req0_ready output 1 port-0 request accepted this cycle
- req0_op input OP_W port-0 ALU operation
- req0_a input DATA_W port-0 operand A
- req0_b input DATA_W port-0 operand B
- rsp0_valid output 1 port-0 result valid
- rsp0_ready input 1 port-0 result consumed
- rsp0_result output DATA_W port-0 result
- rsp0_zero output 1 port-0 zero flag
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as port 0, for port 1
- alu_op output OP_W to shared ALU
- alu_a output DATA_W to shared ALU
- alu_b output DATA_W to shared ALU
- alu_result input DATA_W from shared ALU, combinational
- alu_zero input 1 from shared ALU, combinational
- busy output 1 high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following, and any in-flight operation is discarded with no response:
  - state=IDLE, owner=0, last_grant=1 (so port 0 wins first contention)
  - alu_op/alu_a/alu_b=0, rsp*_result=0, rsp*_zero=0
  - all *_valid/*_ready outputs=0, busy=0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational. It is 1 only for the granted port, and only in IDLE.
  - Grant rules:
    - only req0_valid → port 0
    - only req1_valid → port 1
    - both valid → the port != last_grant
  - On handshake (valid && ready): latch op/a/b into the alu_* registers, set owner and last_grant to the granted port, go to EXEC.
  - With no valid requester, stay in IDLE; alu_* hold their previous values.
- EXEC (exactly 1 cycle):
  - alu_* outputs are stable from registers.
  - At the clock edge, sample alu_result/alu_zero into the owner's rsp registers, then go to RESP.
- RESP:
  - rsp<owner>_valid=1; result and zero are held stable until consumed.
  - rsp<owner>_ready=1 → next state IDLE and rsp_valid drops the next cycle. Otherwise stay in RESP indefinitely.
  - Both req*_ready=0.
  - The non-owner's rsp_valid stays 0.
- Latency: accept at cycle T → rspN_valid at T+2. Minimum issue interval is 3 cycles, because a new accept can occur at T+3 at the earliest.
- Requesters must hold op/a/b stable while valid && !ready. The block samples only on handshake.
- Changes on the unaccepted port are ignored, and so is a valid that drops before grant.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A single active requester is granted back-to-back regardless of last_grant.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Width rule: results pass through unmodified at DATA_W; no truncation or extension inside the block.

Test Plan:
- Reset, then a single request: req0 op=4'b0010, a=5, b=7 at cycle 0 → req0_ready=1 at cycle 0; alu_op=0010/alu_a=5/alu_b=7 at cycle 1; rsp0_valid=1 with result=12, zero=0 at cycle 2; rsp1_valid stays 0.
- Contention: req0 and req1 both valid from reset, rsp*_ready=1 → grants in the order port0, port1, port0, port1; accepts at cycles 0, 3, 6, 9.
- Backpressure: port-1 request a=9, b=9, op=SUB; hold rsp1_ready=0 for 5 cycles → rsp1_valid stays 1, result=0 and zero=1 stay stable, req0_ready=0 throughout even with req0_valid=1; release → IDLE, then port 0 is granted.
- Single requester fairness: only req1_valid, three back-to-back requests → all three granted to port 1; req0_ready never asserted.
- Reset mid-operation: assert rst_n=0 during EXEC of a port-0 request → all outputs 0 immediately (asynchronous); after release, no rsp0_valid is ever produced for the dropped request; the next contention grants port 0 first.
- Operand stability: change req1_a while req1 is waiting behind port 0 → the value present at req1's handshake cycle is the one issued to the ALU.
